imem_boot_loader: RTL

//  Upstream loader stage for the processor. Receives a byte stream (count, words, checksum)
//  and writes 16-bit words into instruction memory from address 0. Holds the core in reset
//  (cpu_hold) until a load completes with a good checksum.
//  It is the synthesizable replacement for loading instruction memory in the bench.

---
 rtl/imem_boot_loader.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
// Loads a boot image into instruction memory. The incoming byte stream has
// this layout:
//     count N (0 means 256), then N x {hi, lo} word pairs, then a checksum.
// The checksum is the XOR of the count byte and every data byte.
// Words are written from address 0 upward. The processor is held in reset
// (o_cpu_hold) until a load finishes with a matching checksum.
//
// Ports
//   i_clock        rising-edge clock
//   i_reset        asynchronous, active-high reset
//   i_start        begin a load (honoured in IDLE, DONE and ERROR only)
//   i_rx_data      stream byte
//   i_rx_valid     i_rx_data is valid
//   o_rx_ready     loader accepts a byte; transfer = valid & ready at the edge
//   o_imem_we      one-cycle instruction-memory write strobe
//   o_imem_addr    write word address
//   o_imem_wdata   write word {hi_byte, lo_byte}
//   o_cpu_hold     1 = keep the processor in reset
//   o_load_done    image loaded and checksum good
//   o_load_error   checksum mismatch, oversize count or receive timeout
//   o_words_loaded words written in the current or last load
// ---------------------------------------------------------------------------
module imem_boot_loader #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [15:0]       o_imem_wdata,
    output logic              o_cpu_hold,
    output logic              o_load_done,
    output logic              o_load_error,
    output logic [ADDR_W:0]   o_words_loaded
);

    localparam int                IDLE_W    = $clog2(TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [8:0]        DEPTH     = 9'(1 << ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
        S_CSUM  = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_rx_ready;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [15:0]         r_wdata;
    logic                r_hold;
    logic                r_done;
    logic                r_error;
    logic [ADDR_W:0]     r_words;
    logic [8:0]          r_count;
    logic [7:0]          r_hi;
    logic [7:0]          r_csum;
    logic [IDLE_W-1:0]   r_idle;

    logic                w_xfer;
    logic                w_rx_state;
    logic                w_start_ok;
    logic                w_idle_expired;
    logic                w_last_word;
    logic [8:0]          w_count_eff;
    logic                w_next_ready;
    logic                w_next_done;
    logic                w_next_error;
    logic                w_next_hold;

    assign w_xfer         = i_rx_valid & r_rx_ready;
    assign w_rx_state     = (r_state == S_COUNT) || (r_state == S_HI) ||
                            (r_state == S_LO)    || (r_state == S_CSUM);
    assign w_start_ok     = i_start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                        (r_state == S_ERROR));
    // r_idle counts the idle cycles already seen, so reaching IDLE_LAST on an
    // idle cycle means this is the TIMEOUT-th consecutive idle cycle.
    assign w_idle_expired = (r_idle == IDLE_LAST);
    assign w_count_eff    = (i_rx_data == 8'd0) ? 9'd256 : {1'b0, i_rx_data};
    // The previous word's index increment lands before the next LO byte, so
    // r_words is the index of the word being accepted now.
    assign w_last_word    = ((9'(r_words) + 9'd1) == r_count);

    // State register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and next-value decode of the state-derived outputs.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (w_start_ok) begin
                    w_next = S_COUNT;
                end else begin
                    w_next = r_state;
                end
            end
            S_COUNT: begin
                if (w_xfer) begin
                    w_next = (w_count_eff > DEPTH) ? S_ERROR : S_HI;
                end else if (w_idle_expired) begin
                    w_next = S_ERROR;
                end else begin
                    w_next = S_COUNT;
                end
            end
            S_HI: begin
                if (w_xfer) begin
                    w_next = S_LO;
                end else if (w_idle_expired) begin
                    w_next = S_ERROR;
                end else begin
                    w_next = S_HI;
                end
            end
            S_LO: begin
                if (w_xfer) begin
                    w_next = w_last_word ? S_CSUM : S_HI;
                end else if (w_idle_expired) begin
                    w_next = S_ERROR;
                end else begin
                    w_next = S_LO;
                end
            end
            S_CSUM: begin
                if (w_xfer) begin
                    w_next = (i_rx_data == r_csum) ? S_DONE : S_ERROR;
                end else if (w_idle_expired) begin
                    w_next = S_ERROR;
                end else begin
                    w_next = S_CSUM;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        w_next_ready = (w_next == S_COUNT) || (w_next == S_HI) ||
                       (w_next == S_LO)    || (w_next == S_CSUM);
        w_next_done  = (w_next == S_DONE);
        w_next_error = (w_next == S_ERROR);
        w_next_hold  = (w_next != S_DONE);
    end

    // Status outputs registered from the next state so they align with it.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rx_ready <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_hold     <= 1'b1;
        end else begin
            r_rx_ready <= w_next_ready;
            r_done     <= w_next_done;
            r_error    <= w_next_error;
            r_hold     <= w_next_hold;
        end
    end

    // Datapath: count, high byte, checksum, idle timer, write port, word index.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 16'h0000;
            r_words <= '0;
            r_count <= 9'd0;
            r_hi    <= 8'h00;
            r_csum  <= 8'h00;
            r_idle  <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_start_ok) begin
                r_words <= '0;
                r_csum  <= 8'h00;
                r_idle  <= '0;
            end else begin
                // Word index advances on the edge that ends the write cycle.
                if (r_we) begin
                    r_words <= r_words + {{ADDR_W{1'b0}}, 1'b1};
                end
                if (w_rx_state) begin
                    r_idle <= w_xfer ? '0 : (r_idle + {{(IDLE_W-1){1'b0}}, 1'b1});
                end
                if (w_xfer) begin
                    case (r_state)
                        S_COUNT: begin
                            r_count <= w_count_eff;
                            r_csum  <= r_csum ^ i_rx_data;
                        end
                        S_HI: begin
                            r_hi   <= i_rx_data;
                            r_csum <= r_csum ^ i_rx_data;
                        end
                        S_LO: begin
                            r_we    <= 1'b1;
                            r_addr  <= r_words[ADDR_W-1:0];
                            r_wdata <= {r_hi, i_rx_data};
                            r_csum  <= r_csum ^ i_rx_data;
                        end
                        default: begin
                            r_csum <= r_csum;
                        end
                    endcase
                end
            end
        end
    end

    assign o_rx_ready     = r_rx_ready;
    assign o_imem_we      = r_we;
    assign o_imem_addr    = r_addr;
    assign o_imem_wdata   = r_wdata;
    assign o_cpu_hold     = r_hold;
    assign o_load_done    = r_done;
    assign o_load_error   = r_error;
    assign o_words_loaded = r_words;

endmodule
